// File: rtl/mipi_csi_pkg.sv
// Shared types, data-type constants, CRC constants and the CSI-2 header ECC for the packetizer.
package mipi_csi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WC_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_GAP
  } state_t;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_YUV422_8 = 6'h1E;
  localparam logic [5:0] LONG_DT_MIN = 6'h10;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

  typedef struct packed {
    logic [1:0]      vc;
    logic [5:0]      dt;
    logic [WC_W-1:0] wc;
  } pkt_cmd_t;

  // Each parity bit is the XOR of the header bits selected by its row mask; d = {WC[15:8], WC[7:0], DI}
  function automatic logic [BYTE_W-1:0] csi_ecc(input logic [23:0] d);
    logic [BYTE_W-1:0] e;
    e    = '0;
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    return e;
  endfunction

endpackage

// File: rtl/mipi_csi_packetizer_if.sv
// Command, payload and serializer byte-interface signals of the CSI-2 packetizer.
interface mipi_csi_packetizer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_vc;
  logic [5:0]  cmd_dt;
  logic [15:0] cmd_wc;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        hs_req;
  logic        re;
  logic [7:0]  data;
  logic        err_underflow;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_vc, cmd_dt, cmd_wc, pl_valid, pl_data, re,
    output cmd_ready, pl_ready, hs_req, data, err_underflow, busy
  );

  modport master (
    output cmd_valid, cmd_vc, cmd_dt, cmd_wc, pl_valid, pl_data, re,
    input  cmd_ready, pl_ready, hs_req, data, err_underflow, busy
  );
endinterface

// File: rtl/mipi_csi_crc16.sv
// Byte-wide CSI-2 payload CRC-16 (reflected 0x1021, LSB first); only built when MIPI_CSI_CRC_EN is defined.
`ifdef MIPI_CSI_CRC_EN
module mipi_csi_crc16
  import mipi_csi_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      x = (x[0] ^ b[i]) ? ((x >> 1) ^ CRC_POLY_REFL) : (x >> 1);
    end
    return x;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) r_crc <= CRC_INIT;
    else if (i_en)        r_crc <= crc_step(r_crc, i_byte);
  end

  assign o_crc = r_crc;

endmodule
`endif

// File: rtl/mipi_csi_packetizer.sv
// CSI-2 short/long packet builder streaming header+ECC, payload and CRC footer one byte per clk_hs.
// MIPI_CSI_CRC_EN selects a computed CRC footer; otherwise the footer is sent as 0x0000.
module mipi_csi_packetizer
  import mipi_csi_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
)
(
  input  logic                  i_clk_hs,
  input  logic                  i_reset,
  mipi_csi_packetizer_if.slave  io_bus
);

  state_t       r_state, w_next;
  pkt_cmd_t     r_cmd;
  logic [7:0]   r_ecc, r_data, w_data_nxt, w_pl_byte;
  logic [1:0]   r_idx, w_idx_nxt;
  logic [15:0]  r_cnt, w_cnt_nxt, w_crc;
  logic         r_hs_req, w_hs_nxt, r_cmd_ready, r_err;
  logic         w_accept, w_consume, w_long, w_fetch_slot, w_fetch;

  assign w_accept     = r_cmd_ready & io_bus.cmd_valid;
  assign w_consume    = r_hs_req & io_bus.re;
  assign w_long       = (r_cmd.dt >= LONG_DT_MIN);
  assign w_fetch_slot = ((r_state == ST_HDR) && (r_idx == 2'd3) && w_long && (r_cmd.wc != 16'd0))
                      || ((r_state == ST_PAYLOAD) && (r_cnt > 16'd1));
  assign w_fetch      = w_consume & w_fetch_slot;
  // A missing payload byte is replaced by zero so the link never stalls
  assign w_pl_byte    = io_bus.pl_valid ? io_bus.pl_data : 8'h00;

`ifdef MIPI_CSI_CRC_EN
  mipi_csi_crc16 u_crc16 (
    .i_clk   (i_clk_hs),
    .i_reset (i_reset),
    .i_clr   (w_accept),
    .i_en    (w_fetch),
    .i_byte  (w_pl_byte),
    .o_crc   (w_crc)
  );
`else
  assign w_crc = 16'h0000;
`endif

  // State and datapath registers
  always_ff @(posedge i_clk_hs) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_ecc       <= 8'h00;
      r_data      <= 8'h00;
      r_idx       <= 2'd0;
      r_cnt       <= 16'd0;
      r_hs_req    <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_data      <= w_data_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hs_req    <= w_hs_nxt;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_err       <= r_err | (w_fetch & ~io_bus.pl_valid);
      if (w_accept) begin
        r_cmd <= '{vc: io_bus.cmd_vc, dt: io_bus.cmd_dt, wc: io_bus.cmd_wc};
        r_ecc <= csi_ecc({io_bus.cmd_wc, io_bus.cmd_vc, io_bus.cmd_dt});
      end
    end
  end

  // Next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_REQ;
      ST_REQ:     if (w_consume) w_next = ST_HDR;
      ST_HDR: begin
        if (w_consume && (r_idx == 2'd3)) begin
          if (!w_long)                    w_next = ST_GAP;
          else if (r_cmd.wc != 16'd0)     w_next = ST_PAYLOAD;
          else                            w_next = ST_CRC;
        end
      end
      ST_PAYLOAD: if (w_consume && (r_cnt == 16'd1)) w_next = ST_CRC;
      ST_CRC:     if (w_consume && r_idx[0]) w_next = ST_GAP;
      ST_GAP:     if (!io_bus.re && (r_cnt == 16'(GAP_CYCLES - 1))) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Next values of the byte lane, burst request and sequencing counters
  always_comb begin
    w_data_nxt = r_data;
    w_hs_nxt   = r_hs_req;
    w_cnt_nxt  = r_cnt;
    w_idx_nxt  = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_data_nxt = {io_bus.cmd_vc, io_bus.cmd_dt};
          w_hs_nxt   = 1'b1;
        end
      end
      ST_REQ: begin
        if (w_consume) begin
          w_data_nxt = r_cmd.wc[7:0];
          w_idx_nxt  = 2'd1;
        end
      end
      ST_HDR: begin
        if (w_consume) begin
          w_idx_nxt = r_idx + 2'd1;
          case (r_idx)
            2'd1:    w_data_nxt = r_cmd.wc[15:8];
            2'd2:    w_data_nxt = r_ecc;
            default: begin
              w_idx_nxt = 2'd0;
              w_cnt_nxt = r_cmd.wc;
              if (!w_long) begin
                w_hs_nxt  = 1'b0;
                w_cnt_nxt = 16'd0;
              end else if (r_cmd.wc != 16'd0) begin
                w_data_nxt = w_pl_byte;
              end else begin
                w_data_nxt = w_crc[7:0];
              end
            end
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (w_consume) begin
          w_cnt_nxt = r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            w_data_nxt = w_crc[7:0];
            w_idx_nxt  = 2'd0;
          end else begin
            w_data_nxt = w_pl_byte;
          end
        end
      end
      ST_CRC: begin
        if (w_consume) begin
          if (!r_idx[0]) begin
            w_data_nxt = w_crc[15:8];
            w_idx_nxt  = 2'd1;
          end else begin
            w_hs_nxt  = 1'b0;
            w_cnt_nxt = 16'd0;
          end
        end
      end
      ST_GAP:  w_cnt_nxt = io_bus.re ? 16'd0 : r_cnt + 16'd1;
      default: w_cnt_nxt = 16'd0;
    endcase
  end

  assign io_bus.cmd_ready     = r_cmd_ready;
  assign io_bus.pl_ready      = w_fetch & io_bus.pl_valid;
  assign io_bus.hs_req        = r_hs_req;
  assign io_bus.data          = r_data;
  assign io_bus.err_underflow = r_err;
  assign io_bus.busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mipi_csi_packetizer.sv
// Directed bench for mipi_csi_packetizer acting as image source and HS serializer.
module tb_mipi_csi_packetizer;
  import mipi_csi_pkg::*;

`ifdef MIPI_CSI_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  logic [7:0] PL_A [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                            8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                            8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
  logic [7:0] PL_B [24] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
                            8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
                            8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mipi_csi_packetizer_if bus ();

  mipi_csi_packetizer #(.GAP_CYCLES(4)) dut (
    .i_clk_hs (clk),
    .i_reset  (reset),
    .io_bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] pl_mem [0:63];
  int pl_n, drop_lo, drop_hi, re_delay, pause_at, stop_after, n_ready;
  logic [7:0] rx [$];
  logic [7:0] ex [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ecc_model(input logic [23:0] d);
    logic [5:0] p;
    p = 6'h00;
    for (int i = 0; i < 24; i++) if (d[i]) p = p ^ ECC_COL[i];
    return {2'b00, p};
  endfunction

  function automatic logic [7:0] sent_byte(input int i);
    logic [7:0] b;
    b = (i >= drop_lo && i <= drop_hi) ? 8'h00 : pl_mem[i[5:0]];
    return b;
  endfunction

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = sent_byte(i);
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  task automatic send_cmd(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    int w = 0;
    while (!bus.cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk("cmd_ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_vc    = vc;
    bus.cmd_dt    = dt;
    bus.cmd_wc    = wc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("hs_req_after_accept", 32'(bus.hs_req), 32'd1);
    chk("data_is_di", 32'(bus.data), 32'({vc, dt}));
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("cmd_ready_while_busy", 32'(bus.cmd_ready), 32'd0);
  endtask

  // Serializer side: consume bytes until hs_req drops (or stop_after bytes collected)
  task automatic run_burst();
    int cyc = 0;
    int hs_cyc = 0;
    int k;
    bit done = 1'b0;
    rx.delete();
    n_ready = 0;
    while (!done && cyc < 300) begin
      bus.re       = (hs_cyc >= re_delay) && (hs_cyc != pause_at);
      k            = rx.size() - 3;
      bus.pl_valid = (k >= 0) && (k < pl_n) && !(k >= drop_lo && k <= drop_hi);
      bus.pl_data  = bus.pl_valid ? pl_mem[k[5:0]] : 8'h00;
      #1;
      if (bus.pl_ready) n_ready++;
      if (bus.re && bus.hs_req) rx.push_back(bus.data);
      if (bus.hs_req) hs_cyc++;
      if (stop_after > 0 && rx.size() == stop_after) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
        if (!bus.hs_req) done = 1'b1;
      end
    end
    chk("burst_terminated", 32'(done), 32'd1);
    bus.re       = 1'b0;
    bus.pl_valid = 1'b0;
  endtask

  task automatic check_gap(input int exp_cycles);
    int w = 0;
    while (!bus.cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk("gap_to_cmd_ready", 32'(w), 32'(exp_cycles));
  endtask

  task automatic build_ex(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input logic [15:0] footer);
    logic [7:0] di;
    di = {vc, dt};
    ex.delete();
    ex.push_back(di);
    ex.push_back(wc[7:0]);
    ex.push_back(wc[15:8]);
    ex.push_back(ecc_model({wc, di}));
    if (dt >= 6'h10) begin
      for (int i = 0; i < int'(wc); i++) ex.push_back(sent_byte(i));
      ex.push_back(footer[7:0]);
      ex.push_back(footer[15:8]);
    end
  endtask

  task automatic cmp_burst(input string tag);
    chk({tag, "_len"}, 32'(rx.size()), 32'(ex.size()));
    for (int i = 0; i < ex.size() && i < rx.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx[i]), 32'(ex[i]));
  endtask

  task automatic load_pl(input bit use_b);
    for (int i = 0; i < 24; i++) pl_mem[i] = use_b ? PL_B[i] : PL_A[i];
    pl_n = 24;
  endtask

  initial begin
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  ecc_b;

    bus.cmd_valid = 1'b0;
    bus.cmd_vc    = 2'd0;
    bus.cmd_dt    = 6'd0;
    bus.cmd_wc    = 16'd0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = 8'h00;
    bus.re        = 1'b0;
    drop_lo = -1; drop_hi = -1; re_delay = 0; pause_at = -1; stop_after = 0; pl_n = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hs_req", 32'(bus.hs_req), 32'd0);
    chk("rst_data", 32'(bus.data), 32'h00);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
    chk("rst_err", 32'(bus.err_underflow), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    // Frame start short packet, re delayed by 2 cycles
    re_delay = 2; pl_n = 0;
    send_cmd(2'd0, DT_FS, 16'h0000);
    run_burst();
    build_ex(2'd0, DT_FS, 16'h0000, 16'h0000);
    cmp_burst("fs_short");
    chk("fs_hs_req_low", 32'(bus.hs_req), 32'd0);
    check_gap(4);

    // RAW8 long packet, reference payload A
    re_delay = 0;
    load_pl(1'b0);
    send_cmd(2'd0, DT_RAW8, 16'd24);
    run_burst();
    build_ex(2'd0, DT_RAW8, 16'd24, CRC_ON ? 16'h00F0 : 16'h0000);
    cmp_burst("raw8_a");
    chk("raw8_a_pl_ready_count", 32'(n_ready), 32'd24);
    check_gap(4);

    // Reference payload B with one re pause mid-payload
    load_pl(1'b1);
    pause_at = 7;
    send_cmd(2'd0, DT_RAW8, 16'd24);
    run_burst();
    build_ex(2'd0, DT_RAW8, 16'd24, CRC_ON ? 16'hE569 : 16'h0000);
    cmp_burst("raw8_b_pause");
    pause_at = -1;
    check_gap(4);

    // Random short headers: ECC against the column-code model
    pl_n = 0;
    for (int n = 0; n < 4; n++) begin
      vc = 2'($urandom_range(0, 3));
      dt = 6'($urandom_range(0, 15));
      wc = 16'($urandom);
      send_cmd(vc, dt, wc);
      run_burst();
      build_ex(vc, dt, wc, 16'h0000);
      cmp_burst($sformatf("rand_hdr%0d", n));
      ecc_b = (rx.size() > 3) ? rx[3] : 8'hFF;
      chk("ecc_bits76_zero", 32'(ecc_b[7:6]), 32'd0);
      check_gap(4);
    end

    // Long packet with zero word count
    send_cmd(2'd1, DT_RAW10, 16'd0);
    run_burst();
    build_ex(2'd1, DT_RAW10, 16'd0, CRC_ON ? 16'hFFFF : 16'h0000);
    cmp_burst("long_wc0");
    chk("no_underflow_yet", 32'(bus.err_underflow), 32'd0);
    check_gap(4);

    // Payload underflow on bytes 5-6 of a 16-byte packet
    for (int i = 0; i < 16; i++) pl_mem[i] = 8'(8'h3C + 8'(i * 37));
    pl_n = 16; drop_lo = 4; drop_hi = 5;
    send_cmd(2'd2, DT_YUV422_8, 16'd16);
    run_burst();
    build_ex(2'd2, DT_YUV422_8, 16'd16, CRC_ON ? crc_model(16) : 16'h0000);
    cmp_burst("underflow");
    chk("underflow_total_bytes", 32'(rx.size()), 32'd22);
    chk("underflow_flag", 32'(bus.err_underflow), 32'd1);
    chk("underflow_pl_ready_count", 32'(n_ready), 32'd14);
    drop_lo = -1; drop_hi = -1;
    check_gap(4);
    chk("underflow_sticky", 32'(bus.err_underflow), 32'd1);

    // Reset while payload byte 3 is on the lane, then a clean packet
    load_pl(1'b0);
    stop_after = 6;
    send_cmd(2'd0, DT_RAW8, 16'd24);
    run_burst();
    stop_after = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_hs_req", 32'(bus.hs_req), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_err_cleared", 32'(bus.err_underflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    send_cmd(2'd3, DT_RAW8, 16'd24);
    run_burst();
    build_ex(2'd3, DT_RAW8, 16'd24, CRC_ON ? 16'h00F0 : 16'h0000);
    cmp_burst("after_rst");
    check_gap(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mipi_csi_packetizer.md
# mipi_csi_packetizer

Builds MIPI CSI-2 short and long packets and streams them one byte per clock into the HS serializer's byte interface (hs_req / re / data). Sits directly upstream of the PHY serializer in the transmit path: the image source issues one packet command plus a payload byte stream, and this block produces the header with ECC, the payload and the CRC-16 footer. It also sequences hs_req so every packet is one HS burst.

## Interface
- GAP_CYCLES, 4: minimum clk_hs cycles between re falling and the next hs_req rise
- clk_hs  in  1  byte clock, shared with the serializer
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  packet command present
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_vc  in  2  virtual channel
- cmd_dt  in  6  data type; dt >= 0x10 is long packet
- cmd_wc  in  16  word count (long) / data field (short)
- pl_valid  in  1  payload byte valid
- pl_ready  out  1  payload byte taken this cycle
- pl_data  in  8  payload byte
- hs_req  out  1  HS burst request to serializer
- re  in  1  serializer read enable
- data  out  8  byte to serializer
- err_underflow  out  1  sticky, payload not available when needed
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, HDR, PAYLOAD, CRC, GAP.
- Consumption: a byte is consumed on a rising edge where re=1 and hs_req=1 (both registered values). re=1 with hs_req=0 is never a consumption.
- IDLE: cmd_ready=1. On accept, latch DI={vc,dt}, WC and ECC. Go to REQ with hs_req<=1 and data<=DI.
- REQ: hold data=DI until first consumption, then HDR.
- HDR: byte order DI, WC[7:0], WC[15:8], ECC. On each consumption, data<=next byte. After the ECC consumption:
  - short packet: end burst.
  - long packet, WC>0: PAYLOAD.
  - long packet, WC=0: CRC with CRC=0xFFFF.
- ECC: CSI-2 6-bit Hamming over the 24 bits {WC[15:8],WC[7:0],DI}; bits 7:6 = 0.
- PAYLOAD: byte counter loads WC, decrements per consumption.
  - Next payload byte is fetched on a consumption edge: pl_ready=1 that cycle when pl_valid=1.
  - If pl_valid=0, send 0x00 instead and set err_underflow. The HS link never stalls.
  - The CRC covers the bytes actually sent.
  - After WC bytes: CRC.
- CRC: CRC-16, poly 0x1021 reflected (0x8408), init 0xFFFF, LSB first, no final XOR. Sent CRC[7:0] then CRC[15:8].
- End of burst: on consumption of the last byte (ECC for short, CRC[15:8] for long), hs_req<=0, then GAP.
- GAP: wait for re=0, then GAP_CYCLES cycles, then IDLE.
- err_underflow clears only on reset.

## Timing
- Reset values: hs_req=0, data=0x00, cmd_ready=0 in the reset cycle then 1, pl_ready=0, err_underflow=0, busy=0, state IDLE.
- Command accept to hs_req high: 1 cycle.
- data changes only on a consumption edge or on the IDLE->REQ edge; data is stable otherwise.
- pl_ready is combinational from state, counter, re and hs_req. It is high at most once per consumption.
- cmd_valid while busy: ignored, not queued.
- Reset mid-burst: next edge forces IDLE and hs_req=0. The partial packet is dropped and the serializer terminates via !hs_req.
- re deasserting mid-packet while hs_req=1: the block holds state and data and resumes on the next consumption.

## Configuration
- MIPI_CSI_CRC_EN defined: CRC computed as above.
- MIPI_CSI_CRC_EN undefined: the CRC datapath is removed and the footer is sent as 0x00,0x00 (CSI-2 "checksum not computed"). All other timing is identical.

## Structure
- Package mipi_csi_pkg holds:
  - state encoding
  - data type constants: FS 0x00, FE 0x01, LS 0x02, LE 0x03, RAW8 0x2A, RAW10 0x2B, YUV422_8 0x1E
  - LONG_DT_MIN = 0x10
  - CRC_INIT = 0xFFFF, CRC_POLY_REFL = 0x8408
  - ECC function
- Sub-module mipi_csi_crc16: byte-wide CRC with clear and enable inputs, and the 16-bit CRC output. Instantiated only under MIPI_CSI_CRC_EN.

## Test plan
- Short packet, vc=0, dt=0x00 (FS), wc=0x0000, re held 1 from 2 cycles after hs_req -> bytes 00 00 00 00, hs_req low after the 4th consumption, cmd_ready returns after re=0 + 4 cycles.
- Long packet, dt=0x2A, wc=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 -> footer F0 00. Repeat with payload FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01 -> footer 69 E5.
- Random DI/WC headers -> ECC byte matches bench Hamming model, bits 7:6 = 0.
- pl_valid dropped for bytes 5-6 of a 16-byte payload -> 0x00 sent in those slots, err_underflow=1, CRC matches the transmitted bytes, total burst 22 bytes.
- Long packet wc=0 -> header, then FF FF. Without MIPI_CSI_CRC_EN, the wc=24 case footer -> 00 00.
- reset asserted during PAYLOAD byte 3 -> next cycle hs_req=0, busy=0. A new command after reset is accepted and sent correctly.
